// File: rtl/xdma_ctrl_pkg.sv
// xdma_ctrl_pkg: shared definitions for the XDMA host control register block.
// Contents: register byte offsets, AXI response codes, write/read channel
// state encodings, and a byte-strobe expansion helper.
package xdma_ctrl_pkg;

    localparam logic [31:0] REG_ID        = 32'h0000_0000;
    localparam logic [31:0] REG_SCRATCH   = 32'h0000_0004;
    localparam logic [31:0] REG_LED       = 32'h0000_0008;
    localparam logic [31:0] REG_CTRL      = 32'h0000_000C;
    localparam logic [31:0] REG_STATUS    = 32'h0000_0010;
    localparam logic [31:0] REG_CYCLES    = 32'h0000_0014;
    localparam logic [31:0] REG_DOORBELLS = 32'h0000_0018;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    // Expand 4 byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/xdma_ctrl_regs.sv
// xdma_ctrl_regs: AXI4-Lite responder for the XDMA host control path.
// Registers: ID, SCRATCH, LED, CTRL (START pulse / SOFT_RST), STATUS
// (BUSY mirror / sticky DONE), CYCLES counter, DOORBELLS (START count).
// Ports:
//   sys_clk, sys_rst_n        clock, async active-low reset
//   s_axil_aw*/w*/b*          AXI-Lite write address, data, response
//   s_axil_ar*/r*             AXI-Lite read address, data
//   leds                      LED register bits
//   start_pulse, soft_rst     datapath control outputs
//   busy_in, done_in          datapath status inputs
module xdma_ctrl_regs
    import xdma_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned LED_W    = 8,
    parameter logic [31:0] BLOCK_ID = 32'h7F4E_0001
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [LED_W-1:0]  leds,
    output logic              start_pulse,
    output logic              soft_rst,
    input  logic              busy_in,
    input  logic              done_in
);

    wr_state_e         wr_q, wr_d;
    rd_state_e         rd_q, rd_d;
    logic              init_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       scratch_q;
    logic [LED_W-1:0]  leds_q;
    logic              soft_rst_q, start_q, done_q;
    logic [31:0]       cycles_q, doorbells_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic [31:0]       wa32, ra32, wd, mask, led32, rd_val;
    logic [3:0]        ws;
    logic [1:0]        rd_resp;
    logic              wr_mapped, start_fire, done_clr;

    function automatic logic [31:0] word_addr(input logic [ADDR_W-1:0] a);
        return 32'(a) & ~32'd3;
    endfunction

    // Readies stay low until the first edge after reset release.
    assign s_axil_awready = init_q && (wr_q == W_IDLE || wr_q == W_HAVE_W);
    assign s_axil_wready  = init_q && (wr_q == W_IDLE || wr_q == W_HAVE_AW);
    assign s_axil_arready = init_q && (rd_q == R_IDLE);
    assign s_axil_bvalid  = (wr_q == W_RESP);
    assign s_axil_rvalid  = (rd_q == R_DATA);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign leds           = leds_q;
    assign start_pulse    = start_q;
    assign soft_rst       = soft_rst_q;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    always_comb begin
        wr_d   = wr_q;
        commit = 1'b0;
        case (wr_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    wr_d   = W_RESP;
                end else if (aw_hs) begin
                    wr_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wr_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs) begin
                commit = 1'b1;
                wr_d   = W_RESP;
            end
            W_HAVE_W: if (aw_hs) begin
                commit = 1'b1;
                wr_d   = W_RESP;
            end
            W_RESP: if (s_axil_bready) wr_d = W_IDLE;
            default: wr_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_d = rd_q;
        case (rd_q)
            R_IDLE:  if (ar_hs) rd_d = R_DATA;
            R_DATA:  if (s_axil_rready) rd_d = R_IDLE;
            default: rd_d = R_IDLE;
        endcase
    end

    // Commit uses whichever half was buffered plus the half arriving now.
    always_comb begin
        wa32       = word_addr((wr_q == W_HAVE_AW) ? awaddr_q : s_axil_awaddr);
        wd         = (wr_q == W_HAVE_W) ? wdata_q : s_axil_wdata;
        ws         = (wr_q == W_HAVE_W) ? wstrb_q : s_axil_wstrb;
        mask       = strb_mask(ws);
        led32      = '0;
        led32[LED_W-1:0] = leds_q;
        wr_mapped  = wa32 inside {REG_ID, REG_SCRATCH, REG_LED, REG_CTRL,
                                  REG_STATUS, REG_CYCLES, REG_DOORBELLS};
        start_fire = commit && (wa32 == REG_CTRL) && ws[0] && wd[0];
        done_clr   = commit && (wa32 == REG_STATUS) && ws[0] && wd[1];
    end

    always_comb begin
        ra32    = word_addr(s_axil_araddr);
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        case (ra32)
            REG_ID:        rd_val = BLOCK_ID;
            REG_SCRATCH:   rd_val = scratch_q;
            REG_LED:       rd_val = led32;
            REG_CTRL:      rd_val = {30'b0, soft_rst_q, 1'b0};
            REG_STATUS:    rd_val = {30'b0, done_q, busy_in};
            REG_CYCLES:    rd_val = cycles_q;
            REG_DOORBELLS: rd_val = doorbells_q;
            default:       rd_resp = RESP_DECERR;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_q        <= W_IDLE;
            rd_q        <= R_IDLE;
            init_q      <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            scratch_q   <= '0;
            leds_q      <= '0;
            soft_rst_q  <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            cycles_q    <= '0;
            doorbells_q <= '0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            init_q   <= 1'b1;
            cycles_q <= cycles_q + 32'd1;
            start_q  <= start_fire;
            if (wr_q == W_IDLE && aw_hs && !w_hs) awaddr_q <= s_axil_awaddr;
            if (wr_q == W_IDLE && w_hs && !aw_hs) begin
                wdata_q <= s_axil_wdata;
                wstrb_q <= s_axil_wstrb;
            end
            if (commit) begin
                bresp_q <= wr_mapped ? RESP_OKAY : RESP_DECERR;
                if (wa32 == REG_SCRATCH) scratch_q <= (scratch_q & ~mask) | (wd & mask);
                if (wa32 == REG_LED) begin
                    leds_q <= LED_W'((led32 & ~mask) | (wd & mask));
                end
                if (wa32 == REG_CTRL && ws[0]) soft_rst_q <= wd[1];
            end
            if (start_fire) doorbells_q <= doorbells_q + 32'd1;
            // A done pulse coincident with a W1C keeps the flag set.
            if (done_in)       done_q <= 1'b1;
            else if (done_clr) done_q <= 1'b0;
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= rd_resp;
            end
        end
    end

endmodule

// File: tb/tb_xdma_ctrl_regs.sv
// tb_xdma_ctrl_regs: directed bench for xdma_ctrl_regs. Stimulus pushes the
// expected B/R responses into queues; a negedge monitor pops and compares.
module tb_xdma_ctrl_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [7:0]  leds;
    logic        start_pulse, soft_rst;
    logic        busy_in = 1'b0, done_in = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } rexp_t;
    rexp_t       rq[$];
    logic [1:0]  bq[$];
    string       bname[$];

    int pulse_cnt = 0;
    int pulse_long = 0;
    logic pulse_prev = 1'b0;

    always #5 clk = ~clk;

    xdma_ctrl_regs #(.ADDR_W(12), .LED_W(8), .BLOCK_ID(32'h7F4E_0001)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready),
        .leds(leds), .start_pulse(start_pulse), .soft_rst(soft_rst),
        .busy_in(busy_in), .done_in(done_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=handshake", name);
    endtask

    // Scoreboard monitor: compares at every R/B handshake.
    always @(negedge clk) begin
        rexp_t e;
        if (rst_n && rvalid && rready) begin
            if (rq.size() == 0) timeout("r_unexpected");
            else begin
                e = rq.pop_front();
                chk({e.name, "_rdata"}, rdata, e.data);
                chk({e.name, "_rresp"}, 32'(rresp), 32'(e.resp));
            end
        end
        if (rst_n && bvalid && bready) begin
            if (bq.size() == 0) timeout("b_unexpected");
            else chk({bname.pop_front(), "_bresp"}, 32'(bresp), 32'(bq.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (start_pulse) begin
            pulse_cnt++;
            if (pulse_prev) pulse_long++;
        end
        pulse_prev = start_pulse;
    end

    task automatic aw_send(input logic [11:0] a);
        bit ok = 0;
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) timeout("aw_wait");
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wready) begin ok = 1; break; end
        end
        if (!ok) timeout("w_wait");
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [11:0] a);
        bit ok = 0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) timeout("ar_wait");
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic expect_b(input logic [1:0] r, input string name);
        bq.push_back(r);
        bname.push_back(name);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] r, input string name);
        expect_b(r, name);
        fork
            aw_send(a);
            w_send(d, s);
        join
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic [1:0] r,
                      input string name);
        rexp_t e;
        e.data = d; e.resp = r; e.name = name;
        rq.push_back(e);
        ar_send(a);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (rq.size() == 0 && bq.size() == 0) break;
            @(posedge clk);
        end
        if (rq.size() != 0 || bq.size() != 0) begin
            timeout("drain");
            rq.delete(); bq.delete(); bname.delete();
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ID read and one-cycle latency
        rd(12'h000, 32'h7F4E_0001, 2'b00, "id");
        chk("id_rvalid_lat", 32'(rvalid), 32'd1);
        drain();

        // SCRATCH: AW first, W first, then byte strobe
        expect_b(2'b00, "scr_aw_first");
        fork
            aw_send(12'h004);
            begin repeat (3) @(posedge clk); #1; w_send(32'hDEAD_BEEF, 4'hF); end
        join
        drain();
        expect_b(2'b00, "scr_w_first");
        fork
            w_send(32'hDEAD_BEEF, 4'hF);
            begin repeat (3) @(posedge clk); #1; aw_send(12'h004); end
        join
        drain();
        wr(12'h004, 32'h0000_00AA, 4'b0001, 2'b00, "scr_strb");
        drain();
        rd(12'h004, 32'hDEAD_BEAA, 2'b00, "scr_rb");
        drain();

        // LED with back-pressured B channel
        bready = 1'b0;
        wr(12'h008, 32'h0000_00A5, 4'hF, 2'b00, "led");
        chk("led_value", 32'(leds), 32'h0000_00A5);
        chk("led_bvalid", 32'(bvalid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("led_hold_bvalid", 32'(bvalid), 32'd1);
            chk("led_hold_bresp", 32'(bresp), 32'd0);
            chk("led_hold_awready", 32'(awready), 32'd0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        drain();

        // START twice
        wr(12'h00C, 32'h1, 4'hF, 2'b00, "start1");
        drain();
        wr(12'h00C, 32'h1, 4'hF, 2'b00, "start2");
        drain();
        repeat (2) @(posedge clk); #1;
        chk("start_pulse_cnt", 32'(pulse_cnt), 32'd2);
        chk("start_pulse_long", 32'(pulse_long), 32'd0);
        rd(12'h018, 32'd2, 2'b00, "doorbells");
        rd(12'h00C, 32'd0, 2'b00, "ctrl_rd0");
        drain();
        wr(12'h00C, 32'h2, 4'hF, 2'b00, "softrst");
        drain();
        chk("soft_rst_level", 32'(soft_rst), 32'd1);
        rd(12'h00C, 32'd2, 2'b00, "ctrl_rd2");
        drain();

        // DONE sticky, set wins over W1C, plain W1C, BUSY mirror
        done_in = 1'b1;
        @(posedge clk); #1;
        done_in = 1'b0;
        rd(12'h010, 32'd2, 2'b00, "status_done");
        drain();
        done_in = 1'b1;
        wr(12'h010, 32'h2, 4'h1, 2'b00, "w1c_vs_done");
        done_in = 1'b0;
        drain();
        rd(12'h010, 32'd2, 2'b00, "status_setwins");
        drain();
        wr(12'h010, 32'h2, 4'h1, 2'b00, "w1c");
        drain();
        rd(12'h010, 32'd0, 2'b00, "status_clr");
        drain();
        busy_in = 1'b1;
        rd(12'h010, 32'd1, 2'b00, "status_busy");
        drain();
        busy_in = 1'b0;

        // Unmapped
        rd(12'h100, 32'd0, 2'b11, "unmapped_rd");
        wr(12'h100, 32'hFFFF_FFFF, 4'hF, 2'b11, "unmapped_wr");
        drain();
        rd(12'h004, 32'hDEAD_BEAA, 2'b00, "scr_after_decerr");
        rd(12'h008, 32'h0000_00A5, 2'b00, "led_after_decerr");
        drain();

        // Reset with read pending
        rready = 1'b0;
        ar_send(12'h004);
        chk("pend_rvalid", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rvalid_now", 32'(rvalid), 32'd0);
        chk("rst2_leds", 32'(leds), 32'd0);
        chk("rst2_soft_rst", 32'(soft_rst), 32'd0);
        chk("rst2_awready", 32'(awready), 32'd0);
        rready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        rd(12'h004, 32'd0, 2'b00, "rst_scratch");
        rd(12'h008, 32'd0, 2'b00, "rst_led");
        rd(12'h00C, 32'd0, 2'b00, "rst_ctrl");
        rd(12'h010, 32'd0, 2'b00, "rst_status");
        rd(12'h018, 32'd0, 2'b00, "rst_doorbells");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
